slv_guard_multi: RTL
====================

SLV_GUARD_MULTI -- requirements
Module: slv_guard_multi

Interface
REQ-001 Parameter NumChan, default 2: number of independently guarded request/response channels, >=1.
REQ-002 Parameter MaxTxns, default 8: maximum outstanding transactions per channel, >=1.
REQ-003 Parameter CntWidth, default 10: width of the per-channel budget and timer.
REQ-004 Derived OutWidth = $clog2(MaxTxns+1); not overridable.
REQ-005 clk_i  in  1  single clock; all state updates on rising edge.
REQ-006 rst_ni  in  1  reset, synchronous, active-low.
REQ-007 guard_ena_i  in  1  enables isolation and reset request; monitoring runs regardless.
REQ-008 mode_i  in  1  0 = report only (irq), 1 = isolate channel and request reset.
REQ-009 budget_i  in  NumChan x CntWidth  per-channel cycle budget; 0 disables that channel's timeout.
REQ-010 req_valid_i / req_ready_o  in/out  NumChan  upstream request handshake.
REQ-011 req_valid_o / req_ready_i  out/in  NumChan  downstream request handshake.
REQ-012 rsp_valid_i / rsp_ready_i  in  NumChan  observed response handshake (monitor only).
REQ-013 clear_i  in  NumChan  per-channel timeout clear pulse.
REQ-014 rst_stat_i  in  1  downstream reset done; clears all channels.
REQ-015 timeout_o  out  NumChan  per-channel timeout flag (registered).
REQ-016 outstanding_o  out  NumChan x OutWidth  per-channel outstanding count.
REQ-017 irq_o  out  1  registered OR of all timeout flags.
REQ-018 rst_req_o  out  1  reset request to system.

Function
REQ-019 Per channel, FSM states IDLE (count 0), BUSY (count>0), TIMEOUT; reset state IDLE.
REQ-020 Request accepted = req_valid_i & req_ready_o; response accepted = rsp_valid_i & rsp_ready_i.
REQ-021 Pass-through: req_valid_o = req_valid_i, req_ready_o = req_ready_i, combinational, unless REQ-022/REQ-023 gate.
REQ-022 Count == MaxTxns: req_valid_o and req_ready_o forced 0 for that channel (no overflow).
REQ-023 State TIMEOUT with guard_ena_i & mode_i: req_valid_o and req_ready_o forced 0 for that channel.
REQ-024 Count: +1 on request only, -1 on response only, unchanged on both or neither.
REQ-025 Response with count 0: ignored, count stays 0, no state change.
REQ-026 IDLE -> BUSY on request accept; BUSY -> IDLE when count reaches 0.
REQ-027 Timer: 0 on entering BUSY and on every response accept; otherwise +1 per BUSY cycle, saturating at all-ones.
REQ-028 BUSY -> TIMEOUT on edge where timer >= budget_i and budget_i != 0 and no response accepted that cycle.
REQ-029 In TIMEOUT, count keeps tracking requests/responses; timer frozen.
REQ-030 TIMEOUT exit on clear_i: next state BUSY if count>0 else IDLE; timer 0; count kept.
REQ-031 rst_stat_i (any state): all channels -> IDLE, count 0, timer 0, timeout flags 0; takes priority over clear_i and handshakes.
REQ-032 timeout_o[c] = (state == TIMEOUT), registered.
REQ-033 irq_o registered: next value = OR of next timeout flags.
REQ-034 rst_req_o = guard_ena_i & mode_i & |timeout_o, combinational from registered flags.
REQ-035 Budget change mid-operation takes effect in the next comparison cycle; no timer reset.

Reset
REQ-036 rst_ni low at an edge: all states IDLE, counts 0, timers 0, timeout_o 0, irq_o 0; rst_req_o 0 follows.
REQ-037 During reset, pass-through still combinational; no handshake counted on a reset edge.

Verification
REQ-038 Budget 4, mode 0: request accepted cycle 0, no response -> timeout_o[0]=1, irq_o=1 from cycle 6; rst_req_o stays 0.
REQ-039 Budget 4, mode 1, guard_ena 1: same stimulus -> from cycle 6 rst_req_o=1, req_ready_o[0]=req_valid_o[0]=0; channel 1 unaffected.
REQ-040 MaxTxns 8: 8 requests, no responses, budget 0 -> outstanding_o=8, 9th request stalled (req_ready_o=0), no timeout.
REQ-041 Simultaneous request and response at count 3 -> count stays 3, timer resets to 0.
REQ-042 In TIMEOUT with count 2: clear_i pulse -> BUSY, timer 0; rst_stat_i instead -> IDLE, count 0, irq_o 0 next cycle.
REQ-043 Response with count 0 -> count 0, state IDLE; rst_ni low mid-BUSY -> all outputs 0 next cycle.

Source files
------------

// File: rtl/slv_guard_multi.sv
// -----------------------------------------------------------------------------
// slv_guard_multi
//
// Guards NumChan independent request/response channels that sit in front of a
// downstream subordinate. For each channel the block counts outstanding
// transactions and times how long the channel has gone without a response.
// When a channel has been waiting longer than its budget, it enters TIMEOUT.
// If guarding is enabled in isolate mode, the channel is then cut off from new
// requests and a system reset is requested. Otherwise only an interrupt is
// raised.
//
// Parameters
//   NumChan   number of guarded channels (>= 1)
//   MaxTxns   maximum outstanding transactions per channel (>= 1)
//   CntWidth  width of the per-channel budget and timer
//   OutWidth  derived width of the outstanding counter (not overridable)
//
// Ports
//   clk_i          clock; all state updates on the rising edge
//   rst_ni         synchronous active-low reset
//   guard_ena_i    enables isolation and reset request (monitoring always on)
//   mode_i         0 = report only, 1 = isolate channel and request reset
//   budget_i       per-channel cycle budget; 0 disables that channel's timeout
//   req_valid_i    upstream request valid, per channel
//   req_ready_o    upstream request ready, per channel
//   req_valid_o    downstream request valid, per channel
//   req_ready_i    downstream request ready, per channel
//   rsp_valid_i    observed response valid, per channel (monitor only)
//   rsp_ready_i    observed response ready, per channel (monitor only)
//   clear_i        per-channel timeout clear pulse
//   rst_stat_i     downstream reset done; returns every channel to IDLE
//   timeout_o      per-channel registered timeout flag
//   outstanding_o  per-channel outstanding transaction count
//   irq_o          registered OR of all timeout flags
//   rst_req_o      reset request to the system
// -----------------------------------------------------------------------------
module slv_guard_multi #(
    parameter  int unsigned NumChan  = 2,
    parameter  int unsigned MaxTxns  = 8,
    parameter  int unsigned CntWidth = 10,
    localparam int unsigned OutWidth = $clog2(MaxTxns + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               guard_ena_i,
    input  logic                               mode_i,
    input  logic [NumChan-1:0][CntWidth-1:0]   budget_i,
    input  logic [NumChan-1:0]                 req_valid_i,
    output logic [NumChan-1:0]                 req_ready_o,
    output logic [NumChan-1:0]                 req_valid_o,
    input  logic [NumChan-1:0]                 req_ready_i,
    input  logic [NumChan-1:0]                 rsp_valid_i,
    input  logic [NumChan-1:0]                 rsp_ready_i,
    input  logic [NumChan-1:0]                 clear_i,
    input  logic                               rst_stat_i,
    output logic [NumChan-1:0]                 timeout_o,
    output logic [NumChan-1:0][OutWidth-1:0]   outstanding_o,
    output logic                               irq_o,
    output logic                               rst_req_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_e;

    // Isolation applies only when both the guard and isolate mode are on.
    logic isolate_ena;
    assign isolate_ena = guard_ena_i & mode_i;

    logic [NumChan-1:0] timeout_d;
    logic [NumChan-1:0] timeout_q;
    logic               irq_q;

    for (genvar c = 0; c < NumChan; c++) begin : g_chan

        state_e              state_q, state_d;
        logic [OutWidth-1:0] cnt_q, cnt_d;
        logic [CntWidth-1:0] timer_q, timer_d;
        logic [CntWidth-1:0] timer_inc;

        logic full;      // no room for another transaction
        logic isolated;  // channel cut off after a timeout
        logic gate;      // block the request path this cycle
        logic req_acc;   // request handshake completes this cycle
        logic rsp_acc;   // response handshake completes this cycle
        logic rsp_eff;   // response that actually retires a transaction
        logic budget_on; // this channel's timeout is enabled

        assign full      = (cnt_q == OutWidth'(MaxTxns));
        assign isolated  = isolate_ena & (state_q == ST_TIMEOUT);
        assign gate      = full | isolated;
        assign budget_on = (budget_i[c] != '0);

        // Pass-through stays purely combinational, including during reset,
        // so the gate depends only on registered state and the two mode bits.
        assign req_valid_o[c] = req_valid_i[c] & ~gate;
        assign req_ready_o[c] = req_ready_i[c] & ~gate;

        assign req_acc = req_valid_i[c] & req_ready_o[c];
        assign rsp_acc = rsp_valid_i[c] & rsp_ready_i[c];
        // A response with nothing outstanding is ignored, so the counter can
        // never wrap below zero.
        assign rsp_eff = rsp_acc & (cnt_q != '0);

        // Saturating increment: the timer parks at all-ones instead of
        // wrapping back below the budget.
        assign timer_inc = (&timer_q) ? timer_q : timer_q + CntWidth'(1);

        // NOTE: every signal written here gets a default value first, so no
        // path leaves it unassigned and no latch is inferred.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            timer_d = timer_q;

            // Outstanding count tracks handshakes in every state; a request and
            // a response in the same cycle cancel out.
            if (req_acc && !rsp_eff) begin
                cnt_d = cnt_q + OutWidth'(1);
            end else if (rsp_eff && !req_acc) begin
                cnt_d = cnt_q - OutWidth'(1);
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (req_acc) begin
                        state_d = ST_BUSY;
                        timer_d = '0;
                    end
                end

                ST_BUSY: begin
                    if (cnt_d == '0) begin
                        // Last transaction retired.
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else if (rsp_acc) begin
                        // Forward progress restarts the wait.
                        timer_d = '0;
                    end else if (budget_on && (timer_q >= budget_i[c])) begin
                        // Timer is frozen from here until the channel is
                        // cleared.
                        state_d = ST_TIMEOUT;
                    end else begin
                        timer_d = timer_inc;
                    end
                end

                ST_TIMEOUT: begin
                    // Count keeps tracking; resume according to what is still
                    // outstanding after this cycle's handshakes.
                    if (clear_i[c]) begin
                        state_d = (cnt_d != '0) ? ST_BUSY : ST_IDLE;
                        timer_d = '0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    timer_d = '0;
                end
            endcase

            // Downstream reset completed: everything the channel knew about
            // in-flight traffic is void, whatever else happens this cycle.
            if (rst_stat_i) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                timer_d = '0;
            end
        end

        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of every other register.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                timer_q <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                timer_q <= timer_d;
            end
        end

        assign timeout_d[c]     = (state_d == ST_TIMEOUT);
        assign outstanding_o[c] = cnt_q;

    end : g_chan

    // Flags and interrupt are registered copies of the next channel states,
    // so they line up exactly with the state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            timeout_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
            irq_q     <= |timeout_d;
        end
    end

    assign timeout_o = timeout_q;
    assign irq_o     = irq_q;
    // Combinational from registered flags so the request drops as soon as
    // the guard is disabled or switched to report-only mode.
    assign rst_req_o = isolate_ena & (|timeout_q);

endmodule : slv_guard_multi
